// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, STATUS and DIVISOR registers
module mmio_uart_tx #(
    parameter logic [31:0] UART_BASE   = 32'h0013_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd651
) (
    input  logic        CLK75,
    input  logic        RST,
    input  logic [31:2] MADDR,
    input  logic [31:0] MDATAO,
    input  logic [3:0]  MWSTB,
    input  logic        WE,
    input  logic        RE,
    output logic        SEL,
    output logic [31:0] RDATA,
    output logic        TXD
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic ovf, full, empty, push, push_ok, pop, sts_wr, div_wr, bit_end, txd_n;
    logic [15:0] divisor, period, period_n, baud, baud_n;
    logic [2:0] bitn, bitn_n;
    logic [7:0] shift, shift_n;
    logic [31:0] status, rd_mux;

    assign SEL     = (WE | RE) && (MADDR[31:4] == UART_BASE[31:4]);
    assign full    = count == DEPTH;
    assign empty   = count == '0;
    assign push    = SEL & WE & (MADDR[3:2] == 2'd0) & MWSTB[0];
    assign push_ok = push & ~full;
    assign sts_wr  = SEL & WE & (MADDR[3:2] == 2'd1);
    assign div_wr  = SEL & WE & (MADDR[3:2] == 2'd2);
    assign status  = {23'b0, 5'(count), ovf, empty, full, state != IDLE};
    assign rd_mux  = MADDR[3:2] == 2'd1 ? status : MADDR[3:2] == 2'd2 ? {16'b0, divisor} : '0;
    assign bit_end = baud == period - 16'd1;

    always_ff @(posedge CLK75)
        if (push_ok) mem[wptr] <= MDATAO[7:0];

    // A push that finds the FIFO full is dropped even if a pop frees a slot on the same edge
    always_ff @(posedge CLK75 or posedge RST)
        if (RST) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            divisor <= DIV_DEFAULT;
            RDATA   <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (push & full) ovf <= 1'b1;
            else if (sts_wr & MWSTB[0] & MDATAO[3]) ovf <= 1'b0;
            if (div_wr & MWSTB[0]) divisor[7:0] <= MDATAO[7:0];
            if (div_wr & MWSTB[1]) divisor[15:8] <= MDATAO[15:8];
            if (SEL & RE) RDATA <= rd_mux;
        end

    always_ff @(posedge CLK75 or posedge RST)
        if (RST) begin
            state  <= IDLE;
            baud   <= '0;
            period <= 16'd2;
            bitn   <= '0;
            shift  <= '0;
            TXD    <= 1'b1;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            period <= period_n;
            bitn   <= bitn_n;
            shift  <= shift_n;
            TXD    <= txd_n;
        end

    // TXD is registered from the next-state view so it only moves on bit boundaries
    always_comb begin
        state_n  = state;
        baud_n   = bit_end ? '0 : baud + 16'd1;
        period_n = period;
        bitn_n   = bitn;
        shift_n  = shift;
        pop      = 1'b0;
        case (state)
            IDLE:  baud_n = '0;
            START: state_n = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                bitn_n  = bitn + 3'd1;
                state_n = bitn == 3'd7 ? STOP : DATA;
            end
            STOP:  state_n = bit_end ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        if (!empty && (state == IDLE || (state == STOP && bit_end))) begin
            pop      = 1'b1;
            state_n  = START;
            shift_n  = mem[rptr];
            period_n = divisor < 16'd2 ? 16'd2 : divisor;
            bitn_n   = '0;
            baud_n   = '0;
        end
        txd_n = state_n == DATA ? shift_n[0] : state_n != START;
    end
endmodule
